// File: rtl/stack_access_ctrl.sv
// -----------------------------------------------------------------------------
// stack_access_ctrl
//   Sequences complete stack operations between the CPU control unit, the stack
//   pointer register and data memory. It runs one operation at a time:
//     push : write memory at SP, then pulse sp_push (SP decrements)
//     pop  : pulse sp_pop (SP increments), wait one cycle, then read memory at SP
//   A push at STACK_LIMIT (overflow) or a pop at STACK_TOP (underflow) is
//   rejected with rsp_err. It does not touch memory or SP.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/ready     request handshake; req_op 0=push 1=pop, req_data push word
//   rsp_valid/err/data  one-cycle completion pulse, error flag, popped word
//   sp_in               current stack pointer value
//   sp_push, sp_pop     one-cycle decrement / increment pulses to the SP register
//   mem_req/we/addr/wdata/rdata/ack
//                       single-access memory port, req held until ack
// -----------------------------------------------------------------------------
module stack_access_ctrl #(
  parameter int unsigned          DATA_W      = 16,
  parameter int unsigned          ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]    STACK_TOP   = 16'hFFFF,
  parameter logic [ADDR_W-1:0]    STACK_LIMIT = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              sp_push,
  output logic              sp_pop,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_MEM,
    PUSH_SP,
    POP_SP,
    POP_WAIT,
    POP_MEM,
    RESP,
    ERR
  } state_t;

  state_t            state, state_nxt;
  logic              op_q;
  logic [DATA_W-1:0] data_q;

  // State register plus the request and response holding registers.
  // NOTE: state uses non-blocking assignments so every flop samples the
  // values from before the edge, whatever order the processes run in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= 1'b0;
      data_q   <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        op_q   <= req_op;
        data_q <= req_data;
      end
      if (state == POP_MEM && mem_ack) begin
        rsp_data <= mem_rdata;
      end
    end
  end

  // Next-state logic. The boundary checks use equality only. The SP register
  // never moves past either end because rejected operations issue no pulse.
  // NOTE: the default assignment first stops a latch from being inferred
  // on paths that do not assign state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (!req_op) state_nxt = (sp_in == STACK_LIMIT) ? ERR : PUSH_MEM;
          else         state_nxt = (sp_in == STACK_TOP)   ? ERR : POP_SP;
        end
      end
      PUSH_MEM: if (mem_ack) state_nxt = PUSH_SP;
      PUSH_SP:               state_nxt = RESP;
      POP_SP:                state_nxt = POP_WAIT;
      // Gives the SP register one cycle to show the incremented value on sp_in.
      POP_WAIT:              state_nxt = POP_MEM;
      POP_MEM:  if (mem_ack) state_nxt = RESP;
      RESP:                  state_nxt = IDLE;
      ERR:                   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the state alone. Address and write data are
  // zero outside memory states so they come out of reset at 0.
  always_comb begin
    req_ready = (state == IDLE);
    sp_push   = (state == PUSH_SP);
    sp_pop    = (state == POP_SP);
    mem_req   = (state == PUSH_MEM) || (state == POP_MEM);
    // op_q is 0 in PUSH_MEM and 1 in POP_MEM, so it selects the direction.
    mem_we    = mem_req && !op_q;
    mem_addr  = mem_req ? sp_in : '0;
    mem_wdata = (state == PUSH_MEM) ? data_q : '0;
    rsp_valid = (state == RESP) || (state == ERR);
    rsp_err   = (state == ERR);
  end

endmodule
